alu_seq: RTL and testbench

Registered, handshaked successor to the 4-bit combinational ALU. It keeps the same x/y/z/w operation encoding and ci/a/b/c/g signal meanings, and adds:
- a WIDTH parameter;
- an accumulator operand mode;
- status flags;
- new shift and multi-cycle shift-add multiply operations.

It sits between the datapath register file and the result bus of the teaching CPU and is driven by a start/busy/done handshake.

---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle ADD/SUB/logic/shift ops plus a
// WIDTH-cycle shift-add MUL, with accumulator operand mode and status flags.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             w,
  input  logic             ci,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] c,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StMul} state_t;
  typedef enum logic [3:0] {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr, OpMul, OpIll} op_t;

  state_t             state_q;
  logic [WIDTH-1:0]   g_q, h_q, c_q, acc_q;
  logic               zf_q, nf_q, cf_q, vf_q, err_q, busy_q, done_q;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;

  op_t                op;
  logic [WIDTH-1:0]   op_a, b_eff, sum, carry_vec;
  logic               carry;
  logic [WIDTH-1:0]   res_g, res_c;
  logic               res_cf, res_vf;
  logic [2*WIDTH-1:0] addend, prod_d;
  logic               mul_last;

  always_comb begin
    op = OpIll;
    if (!x && y && !z)                op = OpAdd;
    else if (x && y && !z)            op = OpSub;
    else if (!x && !y && z && !w)     op = OpAnd;
    else if (!x && !y && z && w)      op = OpOr;
    else if (!x && !y && !z && !w)    op = OpXor;
    else if (x && !y && !z && w)      op = OpShl;
    else if (x && !y && z && !w)      op = OpShr;
    else if (x && !y && !z && !w)     op = OpMul;
  end

  // Ripple adder; SUB reuses it with B inverted and the caller's carry-in.
  always_comb begin
    op_a      = use_acc ? acc_q : a;
    b_eff     = (op == OpSub) ? ~b : b;
    sum       = '0;
    carry_vec = '0;
    carry     = ci;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i]       = op_a[i] ^ b_eff[i] ^ carry;
      carry        = (op_a[i] & b_eff[i]) | (op_a[i] & carry) | (b_eff[i] & carry);
      carry_vec[i] = carry;
    end
  end

  always_comb begin
    res_g  = '0;
    res_c  = '0;
    res_cf = 1'b0;
    res_vf = 1'b0;
    case (op)
      OpAdd, OpSub: begin
        res_g  = sum;
        res_c  = carry_vec;
        res_cf = carry_vec[WIDTH-1];
        res_vf = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OpAnd: res_g = op_a & b;
      OpOr:  res_g = op_a | b;
      OpXor: res_g = op_a ^ b;
      OpShl: begin
        res_g  = {op_a[WIDTH-2:0], ci};
        res_cf = op_a[WIDTH-1];
      end
      OpShr: begin
        res_g  = {ci, op_a[WIDTH-1:1]};
        res_cf = op_a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    addend   = mul_b_q[cnt_q] ? ({{WIDTH{1'b0}}, mul_a_q} << cnt_q) : '0;
    prod_d   = prod_q + addend;
    mul_last = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      g_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (op == OpMul) begin
              mul_a_q <= op_a;
              mul_b_q <= b;
              prod_q  <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StMul;
            end else if (op == OpIll) begin
              // Results, flags and acc hold; only err and done move.
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              g_q    <= res_g;
              h_q    <= '0;
              c_q    <= res_c;
              zf_q   <= (res_g == '0);
              nf_q   <= res_g[WIDTH-1];
              cf_q   <= res_cf;
              vf_q   <= res_vf;
              acc_q  <= res_g;
              err_q  <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        StMul: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          if (mul_last) begin
            g_q     <= prod_d[WIDTH-1:0];
            h_q     <= prod_d[2*WIDTH-1:WIDTH];
            c_q     <= '0;
            zf_q    <= (prod_d[WIDTH-1:0] == '0);
            nf_q    <= prod_d[WIDTH-1];
            cf_q    <= |prod_d[2*WIDTH-1:WIDTH];
            vf_q    <= 1'b0;
            acc_q   <= prod_d[WIDTH-1:0];
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign g    = g_q;
  assign h    = h_q;
  assign c    = c_q;
  assign zf   = zf_q;
  assign nf   = nf_q;
  assign cf   = cf_q;
  assign vf   = vf_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4: expected result vectors are queued
// when an op is driven and compared when done pulses.
module tb_alu_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned OW = 3 * W + 5;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_ILL = 4'b1110;

  logic         clk = 1'b0;
  logic         reset, start, x, y, z, w, ci, use_acc;
  logic [W-1:0] a, b, g, h, c;
  logic         zf, nf, cf, vf, err, busy, done;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs, exp_v;
  int            checks = 0;
  int            errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .z(z), .w(w), .ci(ci),
    .use_acc(use_acc), .a(a), .b(b), .g(g), .h(h), .c(c), .zf(zf), .nf(nf), .cf(cf),
    .vf(vf), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {g, h, c, zf, nf, cf, vf, err};

  function automatic logic [OW-1:0] pack(input logic [W-1:0] eg, eh, ec,
                                         input logic ezf, enf, ecf, evf, eerr);
    return {eg, eh, ec, ezf, enf, ecf, evf, eerr};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] ia, ib,
                       input logic ici, iacc);
    {x, y, z, w} = op;
    a = ia;
    b = ib;
    ci = ici;
    use_acc = iacc;
  endtask

  // Accept one op and return with time just past the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] ia, ib,
                       input logic ici, iacc);
    drive(op, ia, ib, ici, iacc);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    while (!done && n < max_cyc) begin
      cyc();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    start = 1'b0;
    drive(4'b0000, '0, '0, 1'b0, 1'b0);
    do_reset();
    checks++;
    if ({obs, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset: got %h/%b/%b required 0", obs, busy, done);
    end
  endtask

  task automatic test_add_sub();
    int n;
    exp_q.push_back(pack(4'b0110, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(pack(4'b0010, 4'b0000, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(pack(4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       issue(OP_ADD, 4'b1100, 4'b1010, 1'b0, 1'b0);
        1:       issue(OP_SUB, 4'b1100, 4'b1010, 1'b1, 1'b0);
        default: issue(OP_SUB, 4'b0101, 4'b0101, 1'b1, 1'b0);
      endcase
      wait_done(5, n);
      checks++;
      if (n != 0 || !done) begin
        errors++;
        $display("FAIL add_sub_latency[%0d]: got %0d extra cycles required 0", i, n);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL add_sub[%0d]: got %h required %h", i, obs, exp_v);
      end
    end
    cyc();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b required 0", done);
    end
  endtask

  task automatic test_mul();
    int n;
    issue(OP_MUL, 4'b1100, 4'b1010, 1'b0, 1'b0);
    exp_q.push_back(pack(4'b1000, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy: got busy=%b done=%b required 1/0", busy, done);
    end
    // Start while busy must be dropped.
    drive(OP_ADD, 4'b0001, 4'b0001, 1'b0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(10, n);
    checks++;
    if (n + 1 != 4 || !done || busy) begin
      errors++;
      $display("FAIL mul_latency: got %0d edges busy=%b required 4 edges busy=0", n + 1, busy);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mul: got %h required %h", obs, exp_v);
    end
    cyc();
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || g !== 4'b1000) begin
      errors++;
      $display("FAIL mul_no_extra: got done=%b busy=%b g=%b required 0/0/1000", done, busy, g);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(pack(4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(pack(4'b0110, 4'b0000, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(pack(4'b1001, 4'b0000, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    drive(OP_ADD, 4'b1111, 4'b0011, 1'b0, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || obs !== exp_v) begin
        errors++;
        $display("FAIL acc[%0d]: got done=%b %h required %h", i, done, obs, exp_v);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_shift_illegal();
    logic [3:0] ops[4];
    logic [3:0] as[4];
    logic       cis[4];
    ops = '{OP_SHL, OP_ILL, OP_AND, OP_SHR};
    as  = '{4'b1100, 4'b0000, 4'b1100, 4'b0011};
    cis = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_q.push_back(pack(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(pack(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    exp_q.push_back(pack(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(pack(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], 4'b1010, cis[i], 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || obs !== exp_v) begin
        errors++;
        $display("FAIL shift_illegal[%0d]: got done=%b %h required %h", i, done, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    issue(OP_MUL, 4'b1111, 4'b1111, 1'b0, 1'b0);
    exp_q.push_back(pack(4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    checks++;
    if ({obs, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_mul: got %h/%b/%b required 0", obs, busy, done);
    end
    exp_q.push_back(pack(4'b0010, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(OP_ADD, 4'b0001, 4'b0001, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || obs !== exp_v) begin
      errors++;
      $display("FAIL add_after_reset: got done=%b %h required %h", done, obs, exp_v);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_shift_illegal();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
